// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
//   Shared constants and types for the seven-segment scanner slice.
//   Segment patterns are {g,f,e,d,c,b,a}, active-low; anodes are active-low.
//   Contents: SEG_0..SEG_9, SEG_DASH, SEG_OFF, AN_OFF, idx_t, slot_t,
//   an_select() helper (digit index -> active-low one-hot anode pattern).
package seven_seg_pkg;

   localparam logic [6:0] SEG_0    = 7'h40;
   localparam logic [6:0] SEG_1    = 7'h79;
   localparam logic [6:0] SEG_2    = 7'h24;
   localparam logic [6:0] SEG_3    = 7'h30;
   localparam logic [6:0] SEG_4    = 7'h19;
   localparam logic [6:0] SEG_5    = 7'h12;
   localparam logic [6:0] SEG_6    = 7'h02;
   localparam logic [6:0] SEG_7    = 7'h78;
   localparam logic [6:0] SEG_8    = 7'h00;
   localparam logic [6:0] SEG_9    = 7'h10;
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   localparam logic [3:0] AN_OFF   = 4'hF;

   // Digit index: 0 = min0 (rightmost) .. 3 = hr1 (leftmost)
   typedef logic [1:0] idx_t;

   // Per-slot phase: anodes dark (anti-ghosting gap) or digit lit
   typedef enum logic {
      SLOT_BLANK = 1'b0,
      SLOT_ON    = 1'b1
   } slot_t;

   // Active-low anode pattern selecting exactly one digit
   function automatic logic [3:0] an_select(input idx_t idx);
      logic [3:0] an;
      case (idx)
         2'd0:    an = 4'b1110;
         2'd1:    an = 4'b1101;
         2'd2:    an = 4'b1011;
         2'd3:    an = 4'b0111;
         default: an = AN_OFF;
      endcase
      return an;
   endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if
//   Bundles the BCD time digits and the display pins of the scanner.
//   hr1, hr0, min1, min0 : 4-bit BCD digits from the timekeeping side
//   seg                  : 7-bit active-low segments {g,f,e,d,c,b,a}
//   an                   : 4-bit active-low anodes, an[0] = rightmost digit
//   dp                   : active-low decimal point (hr/min separator)
//   master: timekeeping/observer side; slave: the scanner.
interface seven_seg_scanner_if;
   logic [3:0] hr1;
   logic [3:0] hr0;
   logic [3:0] min1;
   logic [3:0] min0;
   logic [6:0] seg;
   logic [3:0] an;
   logic       dp;

   modport master (
      output hr1, hr0, min1, min0,
      input  seg, an, dp
   );

   modport slave (
      input  hr1, hr0, min1, min0,
      output seg, an, dp
   );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode
//   Combinational 4-bit code to 7-segment (active-low) decoder.
//   Codes 0..9 give the decimal digit; 10..15 give a dash.
//   code : 4-bit digit value in
//   seg  : 7-bit active-low segments {g,f,e,d,c,b,a} out
module seg7_decode
   import seven_seg_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   // Digit table lookup
   always_comb begin
      seg = SEG_DASH;
      case (code)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexes the four BCD time digits onto a common-anode 4-digit
//   7-segment display. A tear-free snapshot of the digits is taken at the
//   last cycle of each frame, and every digit slot starts with BLANK_CYC
//   cycles of all anodes off to suppress ghosting.
//   Parameters: SCAN_DIV  clk cycles per digit slot (2..2^20)
//               BLANK_CYC dark cycles at slot start (< SCAN_DIV)
//   Ports: clk   system clock, rising edge
//          reset asynchronous, active-high
//          io    seven_seg_scanner_if.slave (digits in, seg/an/dp out)
//   Build option: SEVEN_SEG_LZB_EN -- when defined, a zero hour-tens digit
//   is left dark instead of showing "0".
module seven_seg_scanner
   import seven_seg_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned BLANK_CYC = 4
)(
   input  logic                clk,
   input  logic                reset,
   seven_seg_scanner_if.slave  io
);

   // 20 bits covers the largest legal prescaler value (2^20 - 1)
   localparam int unsigned  P_W     = 20;
   localparam logic [P_W-1:0] P_LAST  = P_W'(SCAN_DIV - 1);
   localparam logic [P_W-1:0] P_BLANK = P_W'(BLANK_CYC);
   // With no blank gap, the slot is lit from p==0, including right after reset
   localparam slot_t SLOT_RST = (BLANK_CYC == 0) ? SLOT_ON : SLOT_BLANK;

   logic [P_W-1:0] p_r;
   logic [P_W-1:0] p_nxt_s;
   logic           wrap_s;
   idx_t           idx_r;
   logic [15:0]    snap_r;
   slot_t          slot_r;
   slot_t          slot_nxt_s;
   logic [3:0]     digit_s;
   logic [6:0]     seg_dec_s;
   logic [3:0]     an_nxt_s;
   logic [6:0]     seg_nxt_s;
   logic           dp_nxt_s;
   logic [3:0]     an_r;
   logic [6:0]     seg_r;
   logic           dp_r;

   assign wrap_s  = (p_r == P_LAST);
   assign p_nxt_s = wrap_s ? {P_W{1'b0}} : (p_r + {{(P_W-1){1'b0}}, 1'b1});

   // Prescaler and digit index; idx steps on the same edge p wraps to 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_r   <= {P_W{1'b0}};
         idx_r <= 2'd0;
      end else begin
         p_r <= p_nxt_s;
         if (wrap_s) begin
            idx_r <= idx_r + 2'd1;
         end else begin
            idx_r <= idx_r;
         end
      end
   end

   // Frame snapshot, taken on the final cycle of the idx3 slot
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_r <= 16'h0000;
      end else if (wrap_s && (idx_r == 2'd3)) begin
         snap_r <= {io.hr1, io.hr0, io.min1, io.min0};
      end else begin
         snap_r <= snap_r;
      end
   end

   // Slot FSM state register; slot_r always reflects the phase of the current p_r
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_r <= SLOT_RST;
      end else begin
         slot_r <= slot_nxt_s;
      end
   end

   // Slot FSM next state, evaluated against the prescaler value of the next cycle
   always_comb begin
      slot_nxt_s = slot_r;
      case (slot_r)
         SLOT_BLANK: begin
            if (p_nxt_s >= P_BLANK) begin
               slot_nxt_s = SLOT_ON;
            end else begin
               slot_nxt_s = SLOT_BLANK;
            end
         end
         SLOT_ON: begin
            if (wrap_s && (P_BLANK != {P_W{1'b0}})) begin
               slot_nxt_s = SLOT_BLANK;
            end else begin
               slot_nxt_s = SLOT_ON;
            end
         end
         default: slot_nxt_s = SLOT_RST;
      endcase
   end

   // Snapshot nibble for the digit currently being scanned
   always_comb begin
      digit_s = 4'd0;
      case (idx_r)
         2'd0:    digit_s = snap_r[3:0];
         2'd1:    digit_s = snap_r[7:4];
         2'd2:    digit_s = snap_r[11:8];
         2'd3:    digit_s = snap_r[15:12];
         default: digit_s = 4'd0;
      endcase
   end

   seg7_decode u_decode (
      .code (digit_s),
      .seg  (seg_dec_s)
   );

   // Pin values for the current (idx, slot); registered below
   always_comb begin
      an_nxt_s  = AN_OFF;
      seg_nxt_s = SEG_OFF;
      dp_nxt_s  = 1'b1;
      if (slot_r == SLOT_ON) begin
         an_nxt_s  = an_select(idx_r);
         seg_nxt_s = seg_dec_s;
         dp_nxt_s  = (idx_r == 2'd2) ? 1'b0 : 1'b1;
`ifdef SEVEN_SEG_LZB_EN
         // Leading hour zero stays dark; dp is never on in idx3 anyway
         if ((idx_r == 2'd3) && (snap_r[15:12] == 4'd0)) begin
            an_nxt_s  = AN_OFF;
            seg_nxt_s = SEG_OFF;
         end else begin
            an_nxt_s  = an_nxt_s;
            seg_nxt_s = seg_nxt_s;
         end
`endif
      end else begin
         an_nxt_s  = AN_OFF;
         seg_nxt_s = SEG_OFF;
         dp_nxt_s  = 1'b1;
      end
   end

   // Output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_r  <= AN_OFF;
         seg_r <= SEG_OFF;
         dp_r  <= 1'b1;
      end else begin
         an_r  <= an_nxt_s;
         seg_r <= seg_nxt_s;
         dp_r  <= dp_nxt_s;
      end
   end

   assign io.an  = an_r;
   assign io.seg = seg_r;
   assign io.dp  = dp_r;

endmodule
